// File: rtl/reg_file_param.sv
// reg_file_param: parameterised 2R/1W register file with write bypass, zero register,
// reset image and a multi-cycle clear sequencer.
module reg_file_param #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter bit ZERO_REG  = 1,
  parameter bit BYPASS    = 1,
  parameter bit INIT_MODE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              regWrite,
  input  logic [ADDR_W-1:0] writeReg,
  input  logic [DATA_W-1:0] writeData,
  input  logic [ADDR_W-1:0] readReg1,
  input  logic [ADDR_W-1:0] readReg2,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2,
  input  logic              clear_req,
  output logic              busy,
  output logic              clear_done,
  output logic              wr_reject
);
  localparam int NUM_REGS = 2**ADDR_W;
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state, nextState;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [ADDR_W-1:0] clearPtr;
  logic zeroHit, wrEn, rejectNow;
  assign zeroHit   = ZERO_REG && writeReg == '0;
  assign wrEn      = regWrite && state == IDLE && !zeroHit;
  assign rejectNow = regWrite && (state == CLEAR || zeroHit);
  assign busy      = state == CLEAR;
  // wrEn already excludes CLEAR and rejected writes, so it doubles as the bypass qualifier
  assign readData1 = (ZERO_REG && readReg1 == '0) ? '0 :
                     (BYPASS && wrEn && writeReg == readReg1) ? writeData : regs[readReg1];
  assign readData2 = (ZERO_REG && readReg2 == '0) ? '0 :
                     (BYPASS && wrEn && writeReg == readReg2) ? writeData : regs[readReg2];
  always_comb begin
    nextState = state;
    nextState = state == IDLE ? (clear_req ? CLEAR : IDLE) : (&clearPtr ? IDLE : CLEAR);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      clearPtr   <= '0;
      clear_done <= 1'b0;
      wr_reject  <= 1'b0;
    end else begin
      state      <= nextState;
      clearPtr   <= busy ? clearPtr + 1'b1 : '0;
      clear_done <= busy && nextState == IDLE;
      wr_reject  <= rejectNow;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= (INIT_MODE && !(ZERO_REG && i == 0)) ? DATA_W'(i) : '0;
    end else if (busy) begin
      regs[clearPtr] <= '0;
    end else if (wrEn) begin
      regs[writeReg] <= writeData;
    end
  end
endmodule

// File: tb/tb_reg_file_param.sv
// tb_reg_file_param: randomized and directed checks of reg_file_param against an array model.
module tb_reg_file_param;
  logic clk = 0, rst = 1;
  logic regWrite = 0, clear_req = 0;
  logic [4:0] writeReg = 0, readReg1 = 0, readReg2 = 0;
  logic [31:0] writeData = 0, readData1, readData2;
  logic busy, clear_done, wr_reject;
  logic sWe = 0, sClr = 0, sBusy, sDone, sRej;
  logic [2:0] sWa = 0, sR1 = 0, sR2 = 0;
  logic [15:0] sWd = 0, sRd1, sRd2;
  int nChecks = 0, nErrors = 0;
  int busyCnt, doneCnt;
  logic [31:0] mem [32];
  bit clearing;
  int clearIdx;
  always #5 clk = ~clk;

  reg_file_param dut (
    .clk(clk), .rst(rst), .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
    .readReg1(readReg1), .readReg2(readReg2), .readData1(readData1), .readData2(readData2),
    .clear_req(clear_req), .busy(busy), .clear_done(clear_done), .wr_reject(wr_reject)
  );

  reg_file_param #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0), .BYPASS(0)) dutSmall (
    .clk(clk), .rst(rst), .regWrite(sWe), .writeReg(sWa), .writeData(sWd),
    .readReg1(sR1), .readReg2(sR2), .readData1(sRd1), .readData2(sRd2),
    .clear_req(sClr), .busy(sBusy), .clear_done(sDone), .wr_reject(sRej)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic resetModel();
    for (int i = 0; i < 32; i++) mem[i] = (i == 0) ? 0 : i;
    clearing = 0;
    clearIdx = 0;
  endtask

  function automatic logic [31:0] expRead(input logic [4:0] a, input bit rw,
                                          input logic [4:0] wa, input logic [31:0] wd);
    if (a == 0) return 0;
    if (!clearing && rw && wa == a) return wd;
    return mem[a];
  endfunction

  task automatic cycle(input bit rw, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2, input bit cr);
    bit rej, done;
    regWrite = rw; writeReg = wa; writeData = wd; readReg1 = r1; readReg2 = r2; clear_req = cr;
    #1;
    check("read1", readData1, expRead(r1, rw, wa, wd));
    check("read2", readData2, expRead(r2, rw, wa, wd));
    @(posedge clk);
    rej = rw && (clearing || wa == 0);
    done = 0;
    if (clearing) begin
      mem[clearIdx] = 0;
      clearIdx++;
      if (clearIdx == 32) begin clearing = 0; clearIdx = 0; done = 1; end
    end else begin
      if (rw && wa != 0) mem[wa] = wd;
      if (cr) begin clearing = 1; clearIdx = 0; end
    end
    #1;
    check("wr_reject", wr_reject, rej);
    check("clear_done", clear_done, done);
    check("busy", busy, clearing);
    busyCnt += busy;
    doneCnt += clear_done;
    @(negedge clk);
  endtask

  initial begin
    int cnt;
    logic [4:0] wa;
    resetModel();
    repeat (2) @(negedge clk);
    rst = 0;
    readReg1 = 7; readReg2 = 31;
    #1;
    check("rst_r7", readData1, 7);
    check("rst_r31", readData2, 31);
    check("rst_busy", busy, 0);
    check("rst_rej", wr_reject, 0);
    @(negedge clk);
    cycle(1, 5, 32'hDEADBEEF, 5, 7, 0);
    cycle(0, 0, 0, 5, 5, 0);
    cycle(1, 0, 32'h1234, 0, 5, 0);
    cycle(0, 0, 0, 0, 0, 0);
    busyCnt = 0; doneCnt = 0;
    cycle(0, 0, 0, 1, 2, 1);
    for (int i = 0; i < 40; i++)
      cycle(i == 5, 3, $urandom, 3, 5'(i), 0);
    check("clear_busy_cycles", busyCnt, 32);
    check("clear_done_pulses", doneCnt, 1);
    for (int i = 0; i < 16; i++) begin
      cycle(0, 0, 0, 5'(2 * i), 5'(2 * i + 1), 0);
      check("cleared_even", readData1, 0);
    end
    cycle(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 0, 0);
    rst = 1;
    readReg1 = 2; readReg2 = 20;
    #1;
    check("midclr_busy", busy, 0);
    check("midclr_r2", readData1, 2);
    check("midclr_r20", readData2, 20);
    resetModel();
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 400; i++) begin
      wa = 5'($urandom);
      cycle($urandom_range(0, 1), wa, $urandom,
            ($urandom % 4 == 0) ? wa : 5'($urandom), 5'($urandom), $urandom % 60 == 0);
    end
    for (int i = 0; i < 40 && clearing; i++) cycle(0, 0, 0, 0, 0, 0);
    check("drain_clear", clearing, 0);
    sWe = 1; sWa = 0; sWd = 16'hABCD; sR1 = 0; sR2 = 5;
    #1;
    check("s_no_bypass", sRd1, 0);
    check("s_init_r5", sRd2, 5);
    @(negedge clk);
    sWe = 0;
    #1;
    check("s_r0_written", sRd1, 16'hABCD);
    sClr = 1;
    @(posedge clk);
    #1;
    sClr = 0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      cnt += sBusy;
      @(posedge clk);
      #1;
    end
    check("s_clear_cycles", cnt, 8);
    check("s_r0_cleared", sRd1, 0);
    check("s_r5_cleared", sRd2, 0);
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end
endmodule
